// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state encoding, word width and bytes per word.
package dmem_pkg;

    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 single-port storage, synchronous write,
// registered read.
// Ports: clk, rst (async, active-low, clears rdata only), en (access
// strobe), we (store), ok (access allowed), addr (word index),
// wdata (store data), rdata (registered load data, 0 for stores/faults).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              ok,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we && ok) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds between accesses; stores and faults load 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= (we || !ok) ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: Memory-stage data-memory responder with WAIT_CYCLES
// wait states, one-cycle response strobe and pipeline stall request.
// Ports: clk, rst (async, active-low); req_valid/req_we/req_addr/
// req_wdata/req_ready request side; rsp_valid/rsp_rdata/rsp_err
// response side; stall_o freeze request to the hazard unit.
// Optional: define DMEM_ERR_CHECK_EN for misalign/range fault checks.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fire;
    logic              access;
    logic              ok;
    logic              a_we;
    logic [DATA_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;

    assign req_ready = rst && (state == IDLE);
    assign fire      = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign stall_o   = rst && (((state == IDLE) && req_valid) ||
                               (state == WAIT));

    // With zero wait states the array is hit on the acceptance edge,
    // before the request latches are loaded, so bypass them in IDLE.
    always_comb begin
        a_we    = we_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        if (state == IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end
    end

    assign access = ((state == WAIT) && (cnt == 4'd0)) ||
                    (fire && (WAIT_CYCLES == 0));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (fire) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (fire) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [DATA_W:0] LIMIT = (DATA_W+1)'(WORD_BYTES * DEPTH_WORDS);

    logic err_q;

    assign ok = (a_addr[1:0] == 2'b00) && ({1'b0, a_addr} < LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= !ok;
        end
    end

    assign rsp_err = err_q && rsp_valid;
`else
    // Address bits outside the word index are ignored, so accesses wrap.
    logic unused_bits;

    assign unused_bits = ^{a_addr[DATA_W-1:AW+2], a_addr[1:0]};
    assign ok          = 1'b1;
    assign rsp_err     = 1'b0;
`endif

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .en   (access),
        .we   (a_we),
        .ok   (ok),
        .addr (a_addr[AW+1:2]),
        .wdata(a_wdata),
        .rdata(rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder, driving one
// instance with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        stall_o   [2];

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .stall_o(stall_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .stall_o(stall_o[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
    } req_t;

    req_t        sbq0 [$];
    req_t        sbq1 [$];
    logic [31:0] mdl [2][1024];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          last_acc [2];

    function automatic int wc_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Acceptance: record request at the handshake edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst && req_valid[d] && req_ready[d]) begin
                req_t r;
                r.we    = req_we[d];
                r.addr  = req_addr[d];
                r.wdata = req_wdata[d];
                r.acc   = cyc;
                last_acc[d] = cyc;
                if (d == 0) sbq0.push_back(r);
                else        sbq1.push_back(r);
            end
        end
    end

    // Response side: pop and compare against the memory model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                if (d == 0) sbq0.delete();
                else        sbq1.delete();
                check("rst_ready", 32'(req_ready[d]), 32'd0);
                check("rst_stall", 32'(stall_o[d]), 32'd0);
                check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
                check("rst_rdata", rsp_rdata[d], 32'd0);
                check("rst_err", 32'(rsp_err[d]), 32'd0);
            end else if (rsp_valid[d]) begin
                if (qsize(d) == 0) begin
                    check("rsp_unexp", 32'(rsp_valid[d]), 32'd0);
                end else begin
                    req_t        r;
                    logic        err;
                    logic [31:0] exp;
                    logic [9:0]  idx;
                    r = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    idx = r.addr[11:2];
`ifdef DMEM_ERR_CHECK_EN
                    err = (r.addr[1:0] != 2'b00) || (r.addr >= 32'd4096);
`else
                    err = 1'b0;
`endif
                    exp = 32'd0;
                    if (r.we) begin
                        if (!err) mdl[d][idx] = r.wdata;
                    end else if (!err) begin
                        exp = mdl[d][idx];
                    end
                    check("rsp_rdata", rsp_rdata[d], exp);
                    check("rsp_err", 32'(rsp_err[d]), 32'(err));
                    check("latency", 32'(cyc - r.acc), 32'(wc_of(d) + 1));
                    check("resp_stall", 32'(stall_o[d]), 32'd0);
                    check("resp_ready", 32'(req_ready[d]), 32'd0);
                end
            end else if (qsize(d) != 0) begin
                check("wait_stall", 32'(stall_o[d]), 32'd1);
                check("wait_ready", 32'(req_ready[d]), 32'd0);
            end
        end
    end

    // Entered just after a rising edge; returns just after acceptance.
    task automatic send(int d, logic we, logic [31:0] a, logic [31:0] w,
                        bit hold);
        bit got;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = w;
        #1;
        if (req_ready[d]) check("idle_stall", 32'(stall_o[d]), 32'd1);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(posedge clk);
            if (req_ready[d]) got = 1'b1;
        end
        if (!got) check("accept_timeout", 32'(req_ready[d]), 32'd1);
        #1;
        if (!hold) req_valid[d] = 1'b0;
    endtask

    task automatic wait_done(int d);
        for (int k = 0; k < 50 && qsize(d) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (qsize(d) != 0) check("rsp_timeout", 32'(qsize(d)), 32'd0);
    endtask

    task automatic xfer(int d, logic we, logic [31:0] a, logic [31:0] w);
        send(d, we, a, w, 1'b0);
        wait_done(d);
    endtask

    initial begin
        int a1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) req_valid[d] = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_ready0", 32'(req_ready[0]), 32'd1);
        check("rel_ready1", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 32'h10, 32'hDEADBEEF);
            xfer(d, 1'b0, 32'h10, 32'h0);
            xfer(d, 1'b1, 32'h20, 32'hCAFEF00D);
            xfer(d, 1'b1, 32'h30, 32'h0A0B0C0D);
            send(d, 1'b0, 32'h10, 32'h0, 1'b1);
            a1 = last_acc[d];
            send(d, 1'b0, 32'h30, 32'h0, 1'b0);
            check("b2b_gap", 32'(last_acc[d] - a1), 32'(wc_of(d) + 2));
            wait_done(d);
            xfer(d, 1'b1, 32'h0, 32'h12345678);
            xfer(d, 1'b1, 32'h1002, 32'h00000BAD);
            xfer(d, 1'b0, 32'h1000, 32'h0);
            xfer(d, 1'b0, 32'h0, 32'h0);
            xfer(d, 1'b0, 32'h3, 32'h0);
            xfer(d, 1'b1, 32'h3FFC, 32'h77665544);
            xfer(d, 1'b0, 32'hFFC, 32'h0);
        end

        send(0, 1'b1, 32'h20, 32'h55555555, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 32'h20, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("q0_empty", 32'(qsize(0)), 32'd0);
        check("q1_empty", 32'(qsize(1)), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the Memory-stage data-memory interface: it accepts one load or store request at a time from the pipeline's Memory stage over a valid/ready handshake. After a configurable number of wait states it returns a one-cycle response carrying load data or a store acknowledge. It also drives a stall request that the hazard unit uses to freeze the pipeline while an access is outstanding. It replaces the zero-latency data memory, so the core can later front slower storage.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two; AW = clog2(DEPTH_WORDS).
- WAIT_CYCLES, 2, wait states between acceptance and response; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-low.
- req_valid  input  1  Memory stage presents a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept; high only in IDLE with rst high.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data; 0 for stores.
- rsp_err  output  1  access fault; valid with rsp_valid.
- stall_o  output  1  freeze request to the hazard unit.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch we, addr and wdata.
  - If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt=0, go to RESP; the array access happens on that edge.
- Array access:
  - Store writes wdata at index addr[AW+1:2].
  - Load captures the word into rsp_rdata.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - req_inputs are ignored in RESP.
- stall_o = (IDLE & req_valid) | WAIT. It is low in RESP so the pipeline advances in the same cycle rsp_rdata is valid.
- Requests are non-overlapping. Throughput is one access per WAIT_CYCLES+2 cycles; a back-to-back request is accepted in the IDLE cycle following RESP.
- rsp_rdata holds its last value outside RESP; only rsp_valid qualifies it.
- req_valid dropping while in WAIT does not cancel the latched access.

## Timing
- Acceptance edge N → rsp_valid high in cycle N+WAIT_CYCLES+1.
- Store commit occurs on the edge entering RESP.
- Reset values:
  - state=IDLE, cnt=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 and stall_o=0 while rst is low.
- Reset mid-access: return to IDLE immediately; an uncommitted store is discarded; no response is issued.
- Memory contents are not reset.
- Load and store to the same address in consecutive accesses: the load returns the newly stored data.
- Address wrap: without error checking, addr bits above AW+1 and bits [1:0] are ignored.

## Configuration
- DMEM_ERR_CHECK_EN defined: an access is a fault if addr[1:0]≠0 or addr ≥ 4·DEPTH_WORDS.
  - A faulting store does not write.
  - A faulting load returns rsp_rdata=0.
  - Both assert rsp_err=1 with rsp_valid, with unchanged latency.
- Not defined: rsp_err is tied to 0, no check logic is built, and addresses wrap as above.

## Structure
- Shared package dmem_pkg holds:
  - state encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - WORD_BYTES=4.
  - DATA_W=32.
- One sub-module, dmem_array: a DEPTH_WORDS×32 single-port array with synchronous write and registered read enable.
- FSM, counter, latches and fault check stay in dmem_responder.

## Test plan
- Reset: hold rst low 3 cycles with req_valid=1 → req_ready=0, stall_o=0, rsp_valid=0; release → req_ready=1.
- Store then load, WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, accepted at edge N → rsp_valid at N+3 with rsp_rdata=0. Then load 0x10 → rsp_rdata=0xDEADBEEF 3 cycles after its acceptance; stall_o high in each acceptance cycle and the 2 WAIT cycles.
- WAIT_CYCLES=0: load accepted at N → rsp_valid at N+1; stall_o high 1 cycle only.
- Back-to-back: hold req_valid high with two loads → second accepted the cycle after the first RESP; req_ready low during WAIT and RESP.
- Reset mid-WAIT: assert rst during a store to 0x20 before its commit → no rsp_valid; a subsequent load of 0x20 returns the prior contents.
- DMEM_ERR_CHECK_EN, DEPTH_WORDS=1024:
  - Store to 0x1002 → rsp_err=1 and memory unchanged.
  - Load from 0x1000 → rsp_err=1, rsp_rdata=0.
  - Without the macro, a load from 0x1000 returns word 0.
